mem_sad_min_tracker: RTL

//  MEM-stage consumer of the EX/MEM SAD outputs (final SAD sum plus row/column tags).

---
 rtl/mem_sad_min_tracker.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_sad_min_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : mem_sad_min_tracker
//  Description : MEM-stage running-minimum tracker for SAD candidates.
//                Accepts one candidate per valid cycle during a search window,
//                keeps the smallest SAD with its row/column tags, and presents
//                the result to write-back through a held Done/DoneAck handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_sad_min_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic                  SadValid,
    input  logic [DATA_WIDTH-1:0] SadIn,
    input  logic [IDX_WIDTH-1:0]  RowIn,
    input  logic [IDX_WIDTH-1:0]  ColIn,
    input  logic                  LastIn,
    input  logic                  DoneAck,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] MinSad,
    output logic [IDX_WIDTH-1:0]  MinRow,
    output logic [IDX_WIDTH-1:0]  MinCol,
    output logic [CNT_WIDTH-1:0]  CandCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] C_SAD_INIT = {DATA_WIDTH{1'b1}};
    localparam logic [IDX_WIDTH-1:0]  C_IDX_ZERO = {IDX_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  C_CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  C_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_next;

    logic [DATA_WIDTH-1:0] r_min_sad;
    logic [IDX_WIDTH-1:0]  r_min_row;
    logic [IDX_WIDTH-1:0]  r_min_col;
    logic [CNT_WIDTH-1:0]  r_cand_count;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_open;
    logic                  w_accept;
    logic                  w_better;
    logic                  w_cnt_sat;

    // Qualify the events that move the datapath: a new window opening,
    // a candidate being accepted, and whether it strictly beats the best so far.
    always_comb begin
        w_open    = (r_state == ST_IDLE) && Start;
        w_accept  = (r_state == ST_SCAN) && SadValid;
        w_better  = (SadIn < r_min_sad);
        w_cnt_sat = &r_cand_count;
    end

    // Next-state logic: LastIn only matters when it rides on a valid beat,
    // and DoneAck wins over Start in DONE so a fresh Start is always required.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (SadValid && LastIn) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (DoneAck) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset returns to IDLE even from the middle of a scan.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == ST_SCAN);
            r_done <= (w_state_next == ST_DONE);
        end
    end

    // Running minimum: cleared when a window opens, updated only on a strictly
    // smaller SAD so that ties keep the earlier candidate's tags.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_min_sad <= C_SAD_INIT;
            r_min_row <= C_IDX_ZERO;
            r_min_col <= C_IDX_ZERO;
        end else if (w_open) begin
            r_min_sad <= C_SAD_INIT;
            r_min_row <= C_IDX_ZERO;
            r_min_col <= C_IDX_ZERO;
        end else if (w_accept && w_better) begin
            r_min_sad <= SadIn;
            r_min_row <= RowIn;
            r_min_col <= ColIn;
        end
    end

    // Candidate counter: cleared on window open, saturates at all-ones.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cand_count <= C_CNT_ZERO;
        end else if (w_open) begin
            r_cand_count <= C_CNT_ZERO;
        end else if (w_accept && !w_cnt_sat) begin
            r_cand_count <= r_cand_count + C_CNT_ONE;
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign MinSad    = r_min_sad;
    assign MinRow    = r_min_row;
    assign MinCol    = r_min_col;
    assign CandCount = r_cand_count;

endmodule
`default_nettype wire
